// File: rtl/bp_mem_block_responder_if.sv
// Block memory request/response bundle between the mem-cmd transducer
// (master) and the block memory responder (slave).
interface bp_mem_block_responder_if #(
  parameter int block_width_p = 512,
  parameter int paddr_width_p = 40
);
  logic                       v_i;
  logic                       w_i;
  logic [paddr_width_p-1:0]   addr_i;
  logic [block_width_p-1:0]   data_i;
  logic [block_width_p/8-1:0] write_mask_i;
  logic                       ready_o;
  logic [block_width_p-1:0]   data_o;
  logic                       v_o;
  logic                       yumi_i;

  modport master (
    output v_i, w_i, addr_i, data_i, write_mask_i, yumi_i,
    input  ready_o, data_o, v_o
  );

  modport slave (
    input  v_i, w_i, addr_i, data_i, write_mask_i, yumi_i,
    output ready_o, data_o, v_o
  );
endinterface

// File: rtl/bp_mem_block_responder.sv
// Block memory responder: fixed-latency, in-order block store model.
// Optional BP_MEM_RANDOM_STALL_EN gates ready_o with a 16-bit LFSR.
module bp_mem_block_responder #(
  parameter int          block_width_p = 512,
  parameter int          paddr_width_p = 40,
  parameter int          mem_els_p     = 1024,
  parameter int          latency_p     = 4,
  parameter int          els_p         = 4,
  parameter logic [15:0] lfsr_seed_p   = 16'hACE1
) (
  input logic                      clk_i,
  input logic                      reset_n_i,
  bp_mem_block_responder_if.slave  mem_if
);
  localparam int BYTES = block_width_p / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(mem_els_p);
  localparam int PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int CNT_W = $clog2(els_p + 1);
  localparam int CD_W  = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

  localparam logic [CD_W-1:0]  LAT  = CD_W'(latency_p);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(els_p);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(els_p - 1);

  logic [block_width_p-1:0] mem_q [mem_els_p];
  logic [block_width_p-1:0] dat_q [els_p];
  logic [CD_W-1:0]          cd_q  [els_p];
  logic [CD_W-1:0]          cd_d  [els_p];
  logic [PTR_W-1:0]         rd_q, rd_d;
  logic [PTR_W-1:0]         wr_q, wr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx;
  logic                     full;
  logic                     ready;
  logic                     head_v;
  logic                     acc;
  logic                     pop;
  logic                     unused_addr;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign idx         = mem_if.addr_i[OFF_W +: IDX_W];
  assign unused_addr = ^mem_if.addr_i;

  assign full   = (cnt_q == FULL);
  assign head_v = (cnt_q != '0) && (cd_q[rd_q] == '0);
  assign acc    = mem_if.v_i & ready;
  assign pop    = mem_if.yumi_i & head_v;

  assign mem_if.ready_o = ready;
  assign mem_if.v_o     = head_v;
  assign mem_if.data_o  = head_v ? dat_q[rd_q] : '0;

`ifdef BP_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign ready  = ~full & lfsr_q[0];

  // Stall pattern generator, restarts from the seed on every reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) lfsr_q <= lfsr_seed_p;
    else            lfsr_q <= lfsr_d;
  end
`else
  localparam logic [15:0] unused_seed = lfsr_seed_p;

  assign ready = ~full;
`endif

  // Queue bookkeeping: pointer advance, occupancy, per-entry countdown
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    for (int i = 0; i < els_p; i++) begin
      cd_d[i] = (cd_q[i] != '0) ? cd_q[i] - CD_W'(1) : '0;
    end
    if (acc) begin
      cd_d[wr_q] = LAT;
      wr_d       = nxt(wr_q);
    end
    if (pop) rd_d = nxt(rd_q);
    case ({acc, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue control state; pending responses are dropped on reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < els_p; i++) cd_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < els_p; i++) cd_q[i] <= cd_d[i];
    end
  end

  // Backing store: byte-masked writes, contents survive reset
  always_ff @(posedge clk_i) begin
    if (acc && mem_if.w_i) begin
      for (int k = 0; k < BYTES; k++) begin
        if (mem_if.write_mask_i[k])
          mem_q[idx][8*k +: 8] <= mem_if.data_i[8*k +: 8];
      end
    end
  end

  // Response payload: read snapshot at accept, zero for writes
  always_ff @(posedge clk_i) begin
    if (acc) dat_q[wr_q] <= mem_if.w_i ? '0 : mem_q[idx];
  end
endmodule

// File: tb/tb_bp_mem_block_responder.sv
// Bench for bp_mem_block_responder: queue/array reference model
// compared every cycle, plus directed literal expectations.
module tb_bp_mem_block_responder;
  localparam int BW  = 512;
  localparam int PW  = 40;
  localparam int ME  = 1024;
  localparam int LAT = 4;
  localparam int EL  = 4;
  localparam int NB  = BW / 8;

  typedef struct {
    logic [BW-1:0] d;
    longint        acc;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_mem_block_responder_if #(.block_width_p(BW), .paddr_width_p(PW)) bus();

  bp_mem_block_responder #(
    .block_width_p(BW), .paddr_width_p(PW), .mem_els_p(ME),
    .latency_p(LAT), .els_p(EL), .lfsr_seed_p(16'hACE1)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .mem_if(bus)
  );

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  bit run = 0;
  bit yumi_en = 0;
  bit last_held = 0;
  longint cyc = 0;
  ent_t q[$];
  logic [BW-1:0] mm [int];
  logic [BW-1:0] got[$];
  longint vq[$];
  logic [15:0] lfsr_m = 16'hACE1;

  function automatic bit m_valid();
    return (q.size() != 0) && (cyc >= q[0].acc + 1 + LAT);
  endfunction

  function automatic bit m_ready();
    bit r;
    r = q.size() < EL;
`ifdef BP_MEM_RANDOM_STALL_EN
    r = r && lfsr_m[0];
`endif
    return r;
  endfunction

  // reference model: program-ordered memory plus in-order response list
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      lfsr_m = 16'hACE1;
    end else begin
      bit mv, mr;
      int ix;
      logic [BW-1:0] t;
      mv = m_valid();
      mr = m_ready();
      if (bus.yumi_i && mv) void'(q.pop_front());
      if (bus.v_i && mr) begin
        ix = int'(bus.addr_i[6 +: 10]);
        if (bus.w_i) begin
          t = mm.exists(ix) ? mm[ix] : '0;
          for (int k = 0; k < NB; k++)
            if (bus.write_mask_i[k]) t[8*k +: 8] = bus.data_i[8*k +: 8];
          mm[ix] = t;
          q.push_back('{d: '0, acc: cyc});
        end else begin
          q.push_back('{d: mm[ix], acc: cyc});
        end
      end
      lfsr_m = {lfsr_m[14:0], lfsr_m[15]^lfsr_m[13]^lfsr_m[12]^lfsr_m[10]};
      cyc++;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n && run) begin
      bit ev;
      ev = m_valid();
      checks++;
      if (bus.v_o !== ev) begin
        errors++;
        $display("FAIL v_o cyc=%0d got %b exp %b", cyc, bus.v_o, ev);
      end
      checks++;
      if (bus.ready_o !== m_ready()) begin
        errors++;
        $display("FAIL ready_o cyc=%0d got %b exp %b",
                 cyc, bus.ready_o, m_ready());
      end
      if (ev) begin
        checks++;
        if (bus.data_o !== q[0].d) begin
          errors++;
          $display("FAIL data_o cyc=%0d got %h exp %h",
                   cyc, bus.data_o, q[0].d);
        end
      end
      if (bus.v_o && !last_held) vq.push_back(cyc);
      if (!bus.ready_o) stalls++;
    end
  end

  task automatic lit(input string n, input logic [BW-1:0] a,
                     input logic [BW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    bus.yumi_i = yumi_en && m_valid();
    if (bus.yumi_i) got.push_back(bus.data_o);
    last_held = bus.v_o && !bus.yumi_i;
  endtask

  task automatic req(input bit w, input logic [PW-1:0] a,
                     input logic [BW-1:0] d, input logic [NB-1:0] m,
                     output longint ac);
    int n;
    n = 0;
    bus.v_i = 1'b1;
    bus.w_i = w;
    bus.addr_i = a;
    bus.data_i = d;
    bus.write_mask_i = m;
    while (!m_ready() && n < 500) begin
      tick();
      n++;
      if (n > 8) yumi_en = 1;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL req_timeout addr %h", a);
    end
    ac = cyc;
    tick();
    bus.v_i = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int t;
    t = 0;
    while (got.size() < n && t < 400) begin
      tick();
      t++;
    end
    checks++;
    if (got.size() < n) begin
      errors++;
      $display("FAIL wait_got got %0d exp %0d", got.size(), n);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    yumi_en = 1;
    bus.v_i = 1'b0;
    while (q.size() != 0 && t < 400) begin
      tick();
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d exp 0", q.size());
    end
  endtask

  initial begin
    longint aw, ar;
    logic [BW-1:0] rd, ones, e;
    logic [NB-1:0] all_m;
    all_m = '1;
    ones = '1;
    bus.v_i = 0;
    bus.w_i = 0;
    bus.addr_i = '0;
    bus.data_i = '0;
    bus.write_mask_i = '0;
    bus.yumi_i = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    run = 1;
    tick();
    lit("rst_v_o", BW'(bus.v_o), '0);
    lit("rst_ready_o", BW'(bus.ready_o), BW'(1));
    lit("rst_data_o", bus.data_o, '0);

    // write then read 0x80, yumi always granted
    yumi_en = 1;
    got.delete();
    vq.delete();
    req(1, 40'h80, {NB{8'hAA}}, all_m, aw);
    req(0, 40'h80, '0, '0, ar);
    wait_got(2);
    lit("wr_resp_zero", got[0], '0);
    lit("rd_resp_aa", got[1], {NB{8'hAA}});
    checks++;
    if (vq.size() < 2 || vq[1] - ar != 5) begin
      errors++;
      $display("FAIL rd_latency got %0d exp 5",
               (vq.size() < 2) ? -1 : vq[1] - ar);
    end

    // partial write over a 0xFF block
    got.delete();
    req(1, 40'h40, ones, all_m, aw);
    req(1, 40'h40, {NB{8'h11}}, NB'(64'hF), aw);
    req(0, 40'h40, '0, '0, ar);
    wait_got(3);
    lit("partial_wr", got[2], {{(NB-4){8'hFF}}, {4{8'h11}}});

    // address alias wraps modulo mem_els_p
    got.delete();
    req(1, PW'(ME*NB + 'h40), {NB{8'h5A}}, all_m, aw);
    req(0, 40'h40, '0, '0, ar);
    wait_got(2);
    lit("alias_rd", got[1], {NB{8'h5A}});

    // fill the queue with yumi withheld
    for (int k = 0; k < 5; k++) begin
      rd = {NB{8'(8 + k)}};
      req(1, PW'((8 + k) * NB), rd, all_m, aw);
    end
    drain();
    got.delete();
    yumi_en = 0;
    bus.v_i = 1;
    bus.w_i = 0;
    bus.write_mask_i = '0;
    for (int k = 0; k < 4; k++) begin
      bus.addr_i = PW'((8 + k) * NB);
      tick();
    end
    bus.addr_i = PW'(12 * NB);
    lit("full_ready", BW'(bus.ready_o), '0);
    repeat (LAT + 1) tick();
    lit("full_v_o", BW'(bus.v_o), BW'(1));
    yumi_en = 1;
    tick();
    yumi_en = 0;
    tick();
    lit("slot_freed", BW'(bus.ready_o), BW'(1));
    tick();
    bus.v_i = 0;
    lit("full_again", BW'(bus.ready_o), '0);
    yumi_en = 1;
    wait_got(5);
    for (int i = 0; i < 5; i++) begin
      e = {NB{8'(8 + i)}};
      lit($sformatf("order_%0d", i), got[i], e);
    end

    // reset with responses pending
    drain();
    got.delete();
    yumi_en = 0;
    for (int k = 0; k < 3; k++) req(0, PW'((8 + k) * NB), '0, '0, ar);
    repeat (LAT + 1) tick();
    lit("pre_rst_v_o", BW'(bus.v_o), BW'(1));
    #2 rst_n = 1'b0;
    #1;
    lit("async_v_o", BW'(bus.v_o), '0);
    lit("async_data_o", bus.data_o, '0);
    tick();
    tick();
    rst_n = 1'b1;
    yumi_en = 1;
    tick();
    lit("post_rst_ready", BW'(bus.ready_o), BW'(1));
    repeat (15) tick();
    lit("no_stale", BW'(got.size()), '0);
    req(0, PW'(9 * NB), '0, '0, ar);
    wait_got(1);
    lit("retained", got[0], {NB{8'h09}});

    // random traffic against the model
    drain();
    for (int k = 0; k < 16; k++) begin
      rd = {16{$urandom()}};
      req(1, PW'(k * NB), rd, all_m, aw);
    end
    for (int i = 0; i < 300; i++) begin
      yumi_en = ($urandom_range(0, 3) != 0);
      rd = {16{$urandom()}};
      req($urandom_range(0, 2) == 0,
          PW'($urandom_range(0, 15) * NB + $urandom_range(0, 3) * ME * NB),
          rd, {2{$urandom()}}, aw);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
`ifdef BP_MEM_RANDOM_STALL_EN
    lit("stalls_seen", BW'(stalls != 0), BW'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
